// File: rtl/stream_mux2_rr.sv
// Two-to-one valid/ready stream merge with round-robin arbitration.
// Output word is registered and tagged with its source channel.
module stream_mux2_rr #(
  parameter int WIDTH     = 2,
  parameter bit RESET_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic             inA_valid,
  output logic             inA_ready,
  input  logic [WIDTH-1:0] inB,
  input  logic             inB_valid,
  output logic             inB_ready,
  output logic [WIDTH-1:0] outY,
  output logic             outY_src,
  output logic             outY_valid,
  input  logic             outY_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             src_q, src_d;
  logic             rr_q, rr_d;

  logic can_load;
  logic gnt_v;
  logic gnt_sel;

  // Arbitration: pick a channel when the output slot frees this cycle.
  always_comb begin
    can_load = (state_q == EMPTY) | outY_ready;
    gnt_v    = 1'b0;
    gnt_sel  = 1'b0;
    if (can_load && !rst) begin
      if (inA_valid && inB_valid) begin
        gnt_v   = 1'b1;
        gnt_sel = rr_q;
      end else if (inA_valid) begin
        gnt_v   = 1'b1;
        gnt_sel = 1'b0;
      end else if (inB_valid) begin
        gnt_v   = 1'b1;
        gnt_sel = 1'b1;
      end
    end
  end

  assign inA_ready = gnt_v & ~gnt_sel;
  assign inB_ready = gnt_v &  gnt_sel;

  // Next state: load the granted word, or drain when consumer takes it.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (gnt_v) begin
      state_d = FULL;
      y_d     = gnt_sel ? inB : inA;
      src_d   = gnt_sel;
      rr_d    = ~gnt_sel;
    end else if (outY_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      src_q   <= 1'b0;
      rr_q    <= RESET_PRI;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign outY       = y_q;
  assign outY_src   = src_q;
  assign outY_valid = (state_q == FULL);

endmodule
